// File: rtl/twiddle_cordic_gen.sv
// Iterative CORDIC twiddle source: phase k -> (cos, sin) of 2*pi*k/2^PHASE_W in Q0.11; result ITER+1 clocks after start.
// No backpressure: one job in flight, start is ignored while busy or in DONE; outputs hold until the next result.
module twiddle_cordic_gen #(
  parameter int PHASE_W = 8,
  parameter int OUT_W   = 12,
  parameter int ITER    = 12,
  parameter int Z_W     = 16,
  parameter int XY_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [PHASE_W-1:0]      phase,
  output logic                    busy,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] cos_2p_by,
  output logic signed [OUT_W-1:0] sin_2p_by
);

  localparam int CNT_W = 4;
  localparam logic signed [XY_W-1:0] X_INIT  = XY_W'(9949);
  localparam logic signed [XY_W+1:0] SAT_MAX = (XY_W+2)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [XY_W+1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [1:0]             quad;
  logic signed [XY_W-1:0] x, y;
  logic signed [Z_W-1:0]  z;

  // atan(2^-i) in angle units where a full turn is 2^16
  function automatic logic signed [Z_W-1:0] atan_lut(input logic [CNT_W-1:0] i);
    case (i)
      4'd0:    atan_lut = Z_W'(8192);
      4'd1:    atan_lut = Z_W'(4836);
      4'd2:    atan_lut = Z_W'(2555);
      4'd3:    atan_lut = Z_W'(1297);
      4'd4:    atan_lut = Z_W'(651);
      4'd5:    atan_lut = Z_W'(326);
      4'd6:    atan_lut = Z_W'(163);
      4'd7:    atan_lut = Z_W'(81);
      4'd8:    atan_lut = Z_W'(41);
      4'd9:    atan_lut = Z_W'(20);
      4'd10:   atan_lut = Z_W'(10);
      4'd11:   atan_lut = Z_W'(5);
      4'd12:   atan_lut = Z_W'(3);
      4'd13:   atan_lut = Z_W'(1);
      default: atan_lut = '0;
    endcase
  endfunction

  // Q1.14 -> Q0.11, round half up, clamp symmetric so -2048 never appears
  function automatic logic signed [OUT_W-1:0] to_q011(input logic signed [XY_W:0] v);
    logic signed [XY_W+1:0] t;
    t = (XY_W+2)'(v) + (XY_W+2)'(4);
    t = t >>> 3;
    if (t > SAT_MAX)      to_q011 = SAT_MAX[OUT_W-1:0];
    else if (t < SAT_MIN) to_q011 = SAT_MIN[OUT_W-1:0];
    else                  to_q011 = t[OUT_W-1:0];
  endfunction

  logic signed [Z_W-1:0]  z_init;
  logic signed [XY_W-1:0] xs, ys, x_n, y_n;
  logic signed [Z_W-1:0]  at, z_n;
  logic signed [XY_W:0]   xe, ye, fc, fs;
  logic signed [OUT_W-1:0] cos_n, sin_n;

  // Quadrant lives in the top two phase bits; the rest is the first-quadrant angle
  assign z_init = {2'b00, phase[PHASE_W-3:0], {(Z_W-PHASE_W){1'b0}}};

  always_comb begin
    xs = x >>> cnt;
    ys = y >>> cnt;
    at = atan_lut(cnt);
    if (!z[Z_W-1]) begin
      x_n = x - ys;
      y_n = y + xs;
      z_n = z - at;
    end else begin
      x_n = x + ys;
      y_n = y - xs;
      z_n = z + at;
    end
  end

  always_comb begin
    xe = (XY_W+1)'(x);
    ye = (XY_W+1)'(y);
    fc = xe;
    fs = ye;
    case (quad)
      2'd1: begin fc = -ye; fs = xe;  end
      2'd2: begin fc = -xe; fs = -ye; end
      2'd3: begin fc = ye;  fs = -xe; end
      default: ;
    endcase
    cos_n = to_q011(fc);
    sin_n = to_q011(fs);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      cos_2p_by <= '0;
      sin_2p_by <= '0;
      cnt       <= '0;
      quad      <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            quad  <= phase[PHASE_W-1:PHASE_W-2];
            x     <= X_INIT;
            y     <= '0;
            z     <= z_init;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ROTATE;
          end
        end
        ROTATE: begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          if (cnt == CNT_W'(ITER-1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          cos_2p_by <= cos_n;
          sin_2p_by <= sin_n;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_cordic_gen.sv
// Directed bench for twiddle_cordic_gen: reset, cardinal/diagonal phases, timing, request handling, full sweep.
module tb_twiddle_cordic_gen;

  localparam int LAT = 13;
  localparam int TOL = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        phase;
  logic              busy;
  logic              out_valid;
  logic signed [11:0] cos_2p_by;
  logic signed [11:0] sin_2p_by;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  twiddle_cordic_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .phase     (phase),
    .busy      (busy),
    .out_valid (out_valid),
    .cos_2p_by (cos_2p_by),
    .sin_2p_by (sin_2p_by)
  );

  function automatic int rnd(input real v);
    if (v >= 0.0) rnd = $rtoi(v + 0.5);
    else          rnd = -$rtoi(-v + 0.5);
  endfunction

  function automatic int ref_cos(input int k);
    ref_cos = rnd(2047.0 * $cos(2.0 * 3.14159265358979 * k / 256.0));
  endfunction

  function automatic int ref_sin(input int k);
    ref_sin = rnd(2047.0 * $sin(2.0 * 3.14159265358979 * k / 256.0));
  endfunction

  function automatic int iabs(input int v);
    iabs = (v < 0) ? -v : v;
  endfunction

  task automatic run_job(input logic [7:0] k, output int lat, output int c, output int s);
    lat = -1; c = 0; s = 0;
    @(negedge clk);
    start = 1'b1;
    phase = k;
    @(posedge clk);
    #1 start = 1'b0;
    for (int m = 0; m <= LAT + 10; m++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = m;
        c = int'(cos_2p_by);
        s = int'(sin_2p_by);
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; phase = 8'd0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (cos_2p_by !== 12'sd0) begin bad++; $display("FAIL reset_cos got=%0d want=0", cos_2p_by); end
    total++; if (sin_2p_by !== 12'sd0) begin bad++; $display("FAIL reset_sin got=%0d want=0", sin_2p_by); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cardinal;
    int lat, c, s;
    int ec[4] = '{2047, 0, -2047, 0};
    int es[4] = '{0, 2047, 0, -2047};
    for (int i = 0; i < 4; i++) begin
      run_job(8'(i * 64), lat, c, s);
      total++; if (lat != LAT) begin bad++; $display("FAIL card_lat k=%0d got=%0d want=%0d", i*64, lat, LAT); end
      total++; if (iabs(c - ec[i]) > TOL) begin bad++; $display("FAIL card_cos k=%0d got=%0d want=%0d", i*64, c, ec[i]); end
      total++; if (iabs(s - es[i]) > TOL) begin bad++; $display("FAIL card_sin k=%0d got=%0d want=%0d", i*64, s, es[i]); end
    end
  endtask

  task automatic test_diag;
    int lat, c, s;
    c = 0; s = 0;
    @(negedge clk);
    start = 1'b1; phase = 8'd32;
    @(posedge clk);
    #1 start = 1'b0;
    for (int m = 0; m <= LAT + 2; m++) begin
      @(negedge clk);
      total++;
      if (busy !== (m < LAT)) begin bad++; $display("FAIL diag_busy m=%0d got=%b want=%b", m, busy, (m < LAT)); end
      total++;
      if (out_valid !== (m == LAT)) begin bad++; $display("FAIL diag_valid m=%0d got=%b want=%b", m, out_valid, (m == LAT)); end
      if (m == LAT) begin c = int'(cos_2p_by); s = int'(sin_2p_by); end
    end
    total++; if (iabs(c - 1448) > TOL) begin bad++; $display("FAIL diag32_cos got=%0d want=1448", c); end
    total++; if (iabs(s - 1448) > TOL) begin bad++; $display("FAIL diag32_sin got=%0d want=1448", s); end
    run_job(8'd224, lat, c, s);
    total++; if (lat != LAT) begin bad++; $display("FAIL diag224_lat got=%0d want=%0d", lat, LAT); end
    total++; if (iabs(c - 1448) > TOL) begin bad++; $display("FAIL diag224_cos got=%0d want=1448", c); end
    total++; if (iabs(s + 1448) > TOL) begin bad++; $display("FAIL diag224_sin got=%0d want=-1448", s); end
  endtask

  task automatic test_reset_mid;
    int lat, c, s;
    bit seen;
    @(negedge clk);
    start = 1'b1; phase = 8'd50;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (cos_2p_by !== 12'sd0) begin bad++; $display("FAIL rstmid_cos got=%0d want=0", cos_2p_by); end
    total++; if (sin_2p_by !== 12'sd0) begin bad++; $display("FAIL rstmid_sin got=%0d want=0", sin_2p_by); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rstmid_stray_valid got=1 want=0"); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle_busy got=%b want=0", busy); end
    run_job(8'd64, lat, c, s);
    total++; if (lat != LAT) begin bad++; $display("FAIL rstmid_lat got=%0d want=%0d", lat, LAT); end
    total++; if (iabs(c) > TOL || iabs(s - 2047) > TOL) begin
      bad++; $display("FAIL rstmid_result got=(%0d,%0d) want=(0,2047)", c, s);
    end
  endtask

  task automatic test_back_to_back;
    int times[$];
    int cs[$];
    int ss[$];
    int ec, es;
    ec = ref_cos(10);
    es = ref_sin(10);
    @(negedge clk);
    start = 1'b1; phase = 8'd10;
    @(posedge clk);
    for (int m = 0; m <= 41; m++) begin
      @(negedge clk);
      if (m == 5) phase = 8'd99;
      if (m == 6) phase = 8'd10;
      if (out_valid) begin
        times.push_back(m);
        cs.push_back(int'(cos_2p_by));
        ss.push_back(int'(sin_2p_by));
      end
    end
    start = 1'b0;
    total++; if (times.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", times.size()); end
    for (int i = 0; i < times.size() && i < 3; i++) begin
      total++;
      if (times[i] != LAT + 14 * i) begin bad++; $display("FAIL b2b_time i=%0d got=%0d want=%0d", i, times[i], LAT + 14*i); end
      total++;
      if (iabs(cs[i] - ec) > TOL || iabs(ss[i] - es) > TOL) begin
        bad++; $display("FAIL b2b_value i=%0d got=(%0d,%0d) want=(%0d,%0d)", i, cs[i], ss[i], ec, es);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_sweep;
    int lat, c, s, ec, es, mag;
    for (int k = 0; k < 256; k++) begin
      run_job(8'(k), lat, c, s);
      ec = ref_cos(k);
      es = ref_sin(k);
      mag = c * c + s * s;
      total++; if (lat != LAT) begin bad++; $display("FAIL sweep_lat k=%0d got=%0d want=%0d", k, lat, LAT); end
      total++; if (iabs(c - ec) > TOL) begin bad++; $display("FAIL sweep_cos k=%0d got=%0d want=%0d", k, c, ec); end
      total++; if (iabs(s - es) > TOL) begin bad++; $display("FAIL sweep_sin k=%0d got=%0d want=%0d", k, s, es); end
      total++;
      if (mag < 4148307 || mag > 4232111) begin
        bad++; $display("FAIL sweep_mag k=%0d got=%0d want=4190209+-1%%", k, mag);
      end
    end
  endtask

  task automatic test_integration;
    int lat, c, s, re, im;
    run_job(8'd64, lat, c, s);
    re = 5 * c - 3 * s;
    im = 5 * s + 3 * c;
    total++; if (iabs(re + 3 * 2047) > 8 * TOL) begin bad++; $display("FAIL integ_re got=%0d want=%0d", re, -3*2047); end
    total++; if (iabs(im - 5 * 2047) > 8 * TOL) begin bad++; $display("FAIL integ_im got=%0d want=%0d", im, 5*2047); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cardinal();
    test_diag();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    test_integration();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
